// File: rtl/dmem_req_unit_pkg.sv
// Shared definitions for the data-memory request issuer: bus width, access-size
// encodings, FSM state codes and the alignment rule.
package dmem_req_unit_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] ZEROWORD = 32'h0000_0000;
    localparam logic            TRUE     = 1'b1;

    localparam logic [1:0] DMEM_SZ_B = 2'b00;
    localparam logic [1:0] DMEM_SZ_H = 2'b01;
    localparam logic [1:0] DMEM_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10,
        ST_DONE   = 2'b11
    } dmem_state_e;

    // Size 11 is illegal and therefore always reported as misaligned.
    function automatic logic dmem_is_misaligned(input logic [1:0] size, input logic [1:0] a_low);
        logic bad;
        case (size)
            DMEM_SZ_B: bad = 1'b0;
            DMEM_SZ_H: bad = a_low[0];
            DMEM_SZ_W: bad = (a_low != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_req_unit_if.sv
// Data-bus side of the request issuer: request/write channel out, grant and
// read-return channel in.
interface dmem_req_unit_if;
    import dmem_req_unit_pkg::*;

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [3:0]      dmem_be_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

endinterface

// File: rtl/dmem_req_unit_store_align.sv
// Combinational lane logic: byte strobes, replicated store data and the raw
// size/alignment check for one access.
module dmem_req_unit_store_align
    import dmem_req_unit_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      a_low,
    input  logic [XLEN-1:0] data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic            misalign
);

    // Strobes follow the addressed lanes; data is replicated so any lane sees it.
    always_comb begin
        be       = 4'b0000;
        wdata    = data;
        misalign = dmem_is_misaligned(size, a_low);
        case (size)
            DMEM_SZ_B: begin
                be    = 4'b0001 << a_low;
                wdata = {4{data[7:0]}};
            end
            DMEM_SZ_H: begin
                be    = 4'b0011 << {a_low[1], 1'b0};
                wdata = {2{data[15:0]}};
            end
            DMEM_SZ_W: begin
                be    = 4'b1111;
                wdata = data;
            end
            default: begin
                be    = 4'b0000;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/dmem_req_unit.sv
// Data-memory request issuer between EX and the data bus: issues one aligned
// request per load/store, runs req/gnt/rvalid, stalls EX and reports errors.
module dmem_req_unit
    import dmem_req_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic              ex_is_load_i,
    input  logic              ex_is_store_i,
    input  logic [1:0]        ex_ls_size_i,
    input  logic [XLEN-1:0]   ex_addr_i,
    input  logic [XLEN-1:0]   ex_store_data_i,
    input  logic              flush_i,
    output logic              ex_stall_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic [1:0]        ls_addr_2low_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              load_data_valid_o,
    dmem_req_unit_if.master   bus
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

    dmem_state_e           state_r;
    dmem_state_e           state_nxt_s;
    logic [TIMEOUT_W-1:0]  cnt_r;
    logic                  killed_r;
    logic                  killed_nxt_s;
    logic                  mem_op_s;
    logic                  misalign_raw_s;
    logic                  start_s;
    logic                  tmo_s;
    logic                  capture_s;
    logic                  err_nxt_s;
    logic                  vld_nxt_s;
    logic [3:0]            be_s;
    logic [XLEN-1:0]       wdata_s;

    dmem_req_unit_store_align u_align (
        .size     (ex_ls_size_i),
        .a_low    (ex_addr_i[1:0]),
        .data     (ex_store_data_i),
        .be       (be_s),
        .wdata    (wdata_s),
        .misalign (misalign_raw_s)
    );

    // Qualify the EX request and detect the last allowed bus-wait cycle.
    always_comb begin
        mem_op_s   = ex_valid_i & (ex_is_load_i | ex_is_store_i);
        misalign_o = mem_op_s & misalign_raw_s;
        start_s    = mem_op_s & ~misalign_raw_s & ~flush_i;
        tmo_s      = (cnt_r == TMO_LAST);
    end

    // Next state, stall, kill tracking and the pulses registered for DONE.
    always_comb begin
        state_nxt_s  = state_r;
        killed_nxt_s = killed_r;
        capture_s    = 1'b0;
        err_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s  = ST_REQ;
                    killed_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A grant in the same cycle as a flush has already committed the access.
                killed_nxt_s = killed_r | flush_i;
                if (bus.dmem_gnt_i) begin
                    state_nxt_s = bus.dmem_we_o ? ST_DONE : ST_WAIT_R;
                end else if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_s) begin
                    state_nxt_s = ST_DONE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT_R: begin
                killed_nxt_s = killed_r | flush_i;
                if (bus.dmem_rvalid_i) begin
                    state_nxt_s = ST_DONE;
                    capture_s   = 1'b1;
                end else if (tmo_s) begin
                    state_nxt_s = ST_DONE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_R;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        vld_nxt_s  = capture_s & ~killed_nxt_s;
        ex_stall_o = ((state_r == ST_IDLE) & start_s) | (state_r == ST_REQ) | (state_r == ST_WAIT_R);
    end

    // Control state: FSM, wait counter, kill flag, request and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            cnt_r             <= '0;
            killed_r          <= 1'b0;
            bus.dmem_req_o    <= 1'b0;
            bus_err_o         <= 1'b0;
            load_data_valid_o <= 1'b0;
        end else begin
            state_r           <= state_nxt_s;
            killed_r          <= killed_nxt_s;
            bus.dmem_req_o    <= (state_nxt_s == ST_REQ) ? TRUE : 1'b0;
            bus_err_o         <= err_nxt_s;
            load_data_valid_o <= vld_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == ST_REQ) || (state_r == ST_WAIT_R)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Access holding registers: latched at start, held stable until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dmem_we_o    <= 1'b0;
            bus.dmem_be_o    <= 4'b0000;
            bus.dmem_addr_o  <= ZEROWORD;
            bus.dmem_wdata_o <= ZEROWORD;
            ls_addr_2low_o   <= 2'b00;
            load_data_o      <= ZEROWORD;
        end else begin
            if ((state_r == ST_IDLE) && start_s) begin
                bus.dmem_we_o    <= ex_is_store_i;
                bus.dmem_be_o    <= be_s;
                bus.dmem_addr_o  <= {ex_addr_i[XLEN-1:2], 2'b00};
                bus.dmem_wdata_o <= wdata_s;
                ls_addr_2low_o   <= ex_addr_i[1:0];
            end else begin
                bus.dmem_we_o    <= bus.dmem_we_o;
                bus.dmem_be_o    <= bus.dmem_be_o;
                bus.dmem_addr_o  <= bus.dmem_addr_o;
                bus.dmem_wdata_o <= bus.dmem_wdata_o;
                ls_addr_2low_o   <= ls_addr_2low_o;
            end
            if (capture_s) begin
                load_data_o <= bus.dmem_rdata_i;
            end else begin
                load_data_o <= load_data_o;
            end
        end
    end

endmodule

// File: tb/tb_dmem_req_unit.sv
// Bench for dmem_req_unit: directed cases then random transactions against a
// per-transaction arithmetic model of stall length, pulses and bus fields.
module tb_dmem_req_unit;
    import dmem_req_unit_pkg::*;

    localparam int TO = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_is_load_i, ex_is_store_i, flush_i;
    logic [1:0]  ex_ls_size_i;
    logic [31:0] ex_addr_i, ex_store_data_i;
    logic        ex_stall_o, misalign_o, bus_err_o, load_data_valid_o;
    logic [1:0]  ls_addr_2low_o;
    logic [31:0] load_data_o;

    int compared   = 0;
    int mismatched = 0;

    dmem_req_unit_if bus ();

    dmem_req_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid_i        (ex_valid_i),
        .ex_is_load_i      (ex_is_load_i),
        .ex_is_store_i     (ex_is_store_i),
        .ex_ls_size_i      (ex_ls_size_i),
        .ex_addr_i         (ex_addr_i),
        .ex_store_data_i   (ex_store_data_i),
        .flush_i           (flush_i),
        .ex_stall_o        (ex_stall_o),
        .misalign_o        (misalign_o),
        .bus_err_o         (bus_err_o),
        .ls_addr_2low_o    (ls_addr_2low_o),
        .load_data_o       (load_data_o),
        .load_data_valid_o (load_data_valid_o),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] a);
        int v;
        if (size == 2'd0)      v = 1 << a;
        else if (size == 2'd1) v = 3 << (a & 2'd2);
        else                   v = 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0)      return {24'd0, d[7:0]} * 32'h0101_0101;
        else if (size == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
        else                   return d;
    endfunction

    task automatic idle_inputs();
        ex_valid_i = 1'b0; ex_is_load_i = 1'b0; ex_is_store_i = 1'b0; flush_i = 1'b0;
        bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
    endtask

    // g: REQ cycles before grant; r: WAIT_R cycles before rvalid; f: stall-cycle index of a flush (-1 none).
    task automatic do_txn(input string tag, input bit is_ld, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int g, input int r, input int f);
        int  s0, exp_stall, stall_cnt, vld_cnt, err_cnt, req_cnt, w, field_bad, idle_bad, c;
        bit  exp_err, exp_vld, dropped, killed, granted, done, alive, end_req;
        logic [31:0] vdata;
        if (g + 1 > TO)       s0 = 1 + TO;
        else if (!is_ld)      s0 = g + 2;
        else if (r + 1 <= TO) s0 = g + r + 3;
        else                  s0 = g + 2 + TO;
        exp_err = (g + 1 > TO) || (is_ld && (g + 1 <= TO) && (r + 1 > TO));
        dropped = (f >= 1) && (f < g + 1) && (f <= TO);
        killed  = (f >= g + 1) && (f < s0);
        if (dropped) begin
            exp_stall = f + 1; exp_err = 1'b0; exp_vld = 1'b0;
        end else begin
            exp_stall = s0; exp_vld = is_ld && !exp_err && !killed;
        end
        stall_cnt = 0; vld_cnt = 0; err_cnt = 0; req_cnt = 0; w = -1; field_bad = 0; c = 0;
        granted = 1'b0; done = 1'b0; alive = 1'b1; end_req = 1'b0; vdata = 32'd0;
        while (!done && c < 4 * TO + 20) begin
            @(posedge clk); #1;
            ex_valid_i = alive; ex_is_load_i = is_ld; ex_is_store_i = !is_ld;
            ex_ls_size_i = size; ex_addr_i = addr; ex_store_data_i = wd;
            flush_i = (c == f);
            bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = $urandom;
            if (!granted) begin
                if (bus.dmem_req_o) begin
                    if (req_cnt == g) begin
                        bus.dmem_gnt_i = 1'b1; granted = 1'b1;
                        if (is_ld) w = 0;
                    end
                    req_cnt++;
                end
            end else if (w >= 0) begin
                if (w == r) begin
                    bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = rd; w = -1;
                end else begin
                    w++;
                end
            end
            @(negedge clk);
            if (ex_stall_o) stall_cnt++;
            else begin done = 1'b1; end_req = bus.dmem_req_o; end
            if (load_data_valid_o) begin vld_cnt++; vdata = load_data_o; end
            if (bus_err_o) err_cnt++;
            if (misalign_o) field_bad++;
            if (bus.dmem_req_o && ((bus.dmem_addr_o !== (addr & 32'hFFFF_FFFC)) ||
                (bus.dmem_be_o !== model_be(size, addr[1:0])) || (bus.dmem_we_o !== !is_ld) ||
                (!is_ld && (bus.dmem_wdata_o !== model_wdata(size, wd)))))
                field_bad++;
            if (flush_i) alive = 1'b0;
            c++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_stall"}, stall_cnt, exp_stall);
        check({tag, "_valid"}, vld_cnt, exp_vld);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_fields"}, field_bad, 0);
        check({tag, "_req_end"}, end_req, 0);
        if (!dropped) check({tag, "_a2low"}, ls_addr_2low_o, addr[1:0]);
        if (exp_vld) check({tag, "_ldata"}, vdata, rd);
        idle_bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            if (bus.dmem_req_o || load_data_valid_o || bus_err_o || ex_stall_o) idle_bad++;
        end
        check({tag, "_idle"}, idle_bad, 0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        bit          ld;
        int          fl;
        rst = 1'b1;
        idle_inputs();
        ex_ls_size_i = 2'b00; ex_addr_i = 32'd0; ex_store_data_i = 32'd0; bus.dmem_rdata_i = 32'd0;
        @(posedge clk); @(negedge clk);
        check("rst_req", bus.dmem_req_o, 0);
        check("rst_stall", ex_stall_o, 0);
        check("rst_pulses", {bus_err_o, load_data_valid_o}, 0);
        check("rst_regs", |{bus.dmem_we_o, bus.dmem_be_o, bus.dmem_addr_o, bus.dmem_wdata_o,
                            ls_addr_2low_o, load_data_o}, 0);
        @(posedge clk); #1 rst = 1'b0;

        do_txn("sb", 1'b0, 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0, -1);
        check("sb_be", bus.dmem_be_o, 4'b1000);
        check("sb_wdata", bus.dmem_wdata_o, 32'hA5A5_A5A5);
        check("sb_addr", bus.dmem_addr_o, 32'h0000_1000);
        do_txn("lw", 1'b1, 2'b10, 32'h0000_2000, 32'd0, 32'hDEAD_BEEF, 3, 1, -1);
        do_txn("sh_w", 1'b0, 2'b01, 32'h0000_0102, 32'h1234_5678, 32'd0, 1, 0, -1);

        // Misaligned half store and illegal-size load: flagged, never issued.
        @(posedge clk); #1;
        ex_valid_i = 1'b1; ex_is_store_i = 1'b1; ex_is_load_i = 1'b0;
        ex_ls_size_i = 2'b01; ex_addr_i = 32'h0000_0001;
        @(negedge clk);
        check("mis_flag", misalign_o, 1);
        check("mis_stall", ex_stall_o, 0);
        @(posedge clk); #1;
        ex_is_store_i = 1'b0; ex_is_load_i = 1'b1; ex_ls_size_i = 2'b11; ex_addr_i = 32'h0000_0040;
        @(negedge clk);
        check("ill_flag", misalign_o, 1);
        check("mis_req", bus.dmem_req_o, 0);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        check("ill_req", bus.dmem_req_o, 0);
        check("mis_clear", misalign_o, 0);

        do_txn("lh_flush_pre", 1'b1, 2'b01, 32'h0000_0010, 32'd0, 32'h1111_2222, 3, 0, 1);
        do_txn("lh_flush_post", 1'b1, 2'b01, 32'h0000_0010, 32'd0, 32'h3333_4444, 1, 3, 3);
        do_txn("timeout_req", 1'b1, 2'b10, 32'h0000_0400, 32'd0, 32'd0, 100, 0, -1);
        do_txn("timeout_rd", 1'b1, 2'b00, 32'h0000_0401, 32'd0, 32'd0, 0, 100, -1);
        do_txn("gnt_at_limit", 1'b0, 2'b10, 32'h0000_0500, 32'hCAFE_F00D, 32'd0, TO - 1, 0, -1);

        // Asynchronous reset while waiting for read data.
        @(posedge clk); #1;
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_is_store_i = 1'b0;
        ex_ls_size_i = 2'b10; ex_addr_i = 32'h0000_3004;
        @(posedge clk); #1 bus.dmem_gnt_i = 1'b1;
        @(posedge clk); #1 bus.dmem_gnt_i = 1'b0;
        @(negedge clk);
        check("wr_stall", ex_stall_o, 1);
        #2 rst = 1'b1; ex_valid_i = 1'b0;
        #1;
        check("async_rst", |{bus.dmem_req_o, bus.dmem_addr_o, bus.dmem_be_o, ex_stall_o,
                             ls_addr_2low_o, load_data_valid_o}, 0);
        @(posedge clk); #1 rst = 1'b0;
        bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        @(posedge clk); #1 bus.dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("post_rst_valid", load_data_valid_o, 0);
        check("post_rst_data", load_data_o, 32'd0);

        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            ld = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
            do_txn($sformatf("rnd%0d", n), ld, sz, a, $urandom, $urandom,
                   int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)), fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
